// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operation encodings, FSM states and fixed constants.
package muldiv_unit_pkg;

  localparam int          ITER_COUNT  = 32;
  localparam logic [31:0] DIV_BY_ZERO = 32'hFFFF_FFFF;

  // funct3 of the M-extension instructions
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  function automatic logic a_is_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_is_signed(input mdu_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// 64-bit conditional two's-complement negator, used both to take operand
// magnitudes and to apply the sign to the final result.
module mdu_negate (
  input  logic [63:0] i_value,
  input  logic        i_negate,
  output logic [63:0] o_value
);

  assign o_value = i_negate ? (~i_value + 64'd1) : i_value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: fixed 32-iteration shift-add multiply
// and restoring divide on operand magnitudes, sign applied on completion.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Flush,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] MDUResult
);

  mdu_state_e  r_state, w_state_next;
  mdu_op_e     w_op_in, r_op;

  logic        w_a_neg, w_b_neg, w_res_neg_in;
  logic [63:0] w_mag_a_full, w_mag_b_full;
  logic [31:0] r_mag_a, r_mag_b;
  logic        r_res_neg, r_div_zero;
  logic [4:0]  r_cnt;
  logic        w_start, w_step, w_last;

  logic [63:0] r_acc, w_acc_next;
  logic [32:0] w_mul_sum;
  logic [31:0] r_rem, r_quo, w_rem_next, w_quo_next;
  logic [32:0] w_rem_shift;
  logic [33:0] w_rem_diff;
  logic        w_q_bit;

  logic [31:0] w_div_sel;
  logic [63:0] w_res_in, w_res_signed;
  logic [31:0] w_result;
  logic        w_unused;

  // ---------------- operand capture ----------------
  assign w_op_in = mdu_op_e'(MDUOp);
  assign w_a_neg = a_is_signed(w_op_in) & SrcA[31];
  assign w_b_neg = b_is_signed(w_op_in) & SrcB[31];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_res_neg_in = w_a_neg ^ w_b_neg;
    if (w_op_in == OP_REM || w_op_in == OP_REMU) w_res_neg_in = w_a_neg;
  end

  mdu_negate u_neg_a (.i_value({32'b0, SrcA}), .i_negate(w_a_neg), .o_value(w_mag_a_full));
  mdu_negate u_neg_b (.i_value({32'b0, SrcB}), .i_negate(w_b_neg), .o_value(w_mag_b_full));

  assign w_start = (r_state == S_IDLE) && Start && !Flush;
  assign w_step  = (r_state == S_CALC) && !Flush;
  assign w_last  = (r_cnt == 5'(ITER_COUNT - 1));

  // ---------------- one iteration ----------------
  // Multiply: product register holds {partial sum, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_mag_a} : 33'd0);
  assign w_acc_next = {w_mul_sum, r_acc[31:1]};

  // Divide: dividend bits shift out of r_quo as quotient bits shift in.
  assign w_rem_shift = {r_rem, r_quo[31]};
  assign w_rem_diff  = {1'b0, w_rem_shift} - {2'b00, r_mag_b};
  assign w_q_bit     = ~w_rem_diff[33];
  assign w_rem_next  = w_q_bit ? w_rem_diff[31:0] : w_rem_shift[31:0];
  assign w_quo_next  = {r_quo[30:0], w_q_bit};

  // ---------------- result formation ----------------
  assign w_div_sel = (r_op == OP_DIV || r_op == OP_DIVU) ? w_quo_next : w_rem_next;
  assign w_res_in  = is_div(r_op) ? {32'b0, w_div_sel} : w_acc_next;

  mdu_negate u_neg_res (.i_value(w_res_in), .i_negate(r_res_neg), .o_value(w_res_signed));

  always_comb begin
    w_result = w_res_signed[31:0];
    unique case (r_op)
      OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_res_signed[63:32];
      OP_DIV, OP_DIVU:              if (r_div_zero) w_result = DIV_BY_ZERO;
      default:                      ;
    endcase
  end

  // Upper magnitude halves are always zero or sign fill; nothing reads them.
  assign w_unused = ^{w_mag_a_full[63:32], w_mag_b_full[63:32], w_rem_diff[32]};

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_CALC;
      S_CALC:  if (Flush) w_state_next = S_IDLE;
               else if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign Busy = (r_state == S_CALC);
  assign Done = (r_state == S_DONE);

  // ---------------- datapath registers ----------------
  // NOTE: datapath registers are reset too, so MDUResult reads 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= OP_MUL;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_res_neg  <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      MDUResult  <= '0;
    end else if (w_start) begin
      r_op       <= w_op_in;
      r_mag_a    <= w_mag_a_full[31:0];
      r_mag_b    <= w_mag_b_full[31:0];
      r_res_neg  <= w_res_neg_in;
      r_div_zero <= (SrcB == 32'd0);
      r_cnt      <= '0;
      r_acc      <= {32'b0, w_mag_b_full[31:0]};
      r_rem      <= '0;
      r_quo      <= w_mag_a_full[31:0];
    end else if (w_step) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= w_acc_next;
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      if (w_last) MDUResult <= w_result;
    end
  end

endmodule
